// File: rtl/simd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simd_pkg : shared row/lane types and drain FSM encoding for the SIMD datapath
// Rev 1.0
// ----------------------------------------------------------------------------
package simd_pkg;

  localparam int unsigned C_PE_COUNT   = 8;
  localparam int unsigned C_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DR_IDLE   = 2'd0,
    DR_FETCH  = 2'd1,
    DR_STREAM = 2'd2,
    DR_FINISH = 2'd3
  } drain_state_t;

  typedef logic [C_PE_COUNT-1:0][C_DATA_WIDTH-1:0] row_t;

  // Index width that stays legal (>=1 bit) even for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_r_drain_row_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// row_serializer : holds one row and emits its lanes, lane 0 first, as AXIS beats
// Rev 1.0
// ----------------------------------------------------------------------------
module row_serializer
  import simd_pkg::*;
#(
  parameter int unsigned PE_COUNT   = C_PE_COUNT,
  parameter int unsigned DATA_WIDTH = C_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_i,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] row_i,
  input  logic                           last_row_i,
  input  logic                           tready_i,
  output logic [DATA_WIDTH-1:0]          tdata_o,
  output logic                           tvalid_o,
  output logic                           tlast_o,
  output logic                           free_o
);

  localparam int unsigned         C_LANE_W    = idx_width(PE_COUNT);
  localparam logic [C_LANE_W-1:0] C_LAST_LANE = C_LANE_W'(PE_COUNT - 1);

  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_q;
  logic [C_LANE_W-1:0]                 lane_q;
  logic                                valid_q;
  logic                                last_row_q;

  logic w_hs;
  logic w_lane_last;
  logic w_row_done;

  assign w_hs        = valid_q & tready_i;
  assign w_lane_last = (lane_q == C_LAST_LANE);
  assign w_row_done  = w_hs & w_lane_last;
  // A new row may replace the current one on the very cycle its last lane leaves.
  assign free_o      = ~valid_q | w_row_done;

  assign tvalid_o = valid_q;
  assign tlast_o  = valid_q & last_row_q & w_lane_last;
  assign tdata_o  = row_q[lane_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      lane_q     <= '0;
      valid_q    <= 1'b0;
      last_row_q <= 1'b0;
    end else if (load_i && free_o) begin
      row_q      <= row_i;
      lane_q     <= '0;
      valid_q    <= 1'b1;
      last_row_q <= last_row_i;
    end else if (w_hs) begin
      if (w_lane_last) begin
        valid_q <= 1'b0;
        lane_q  <= '0;
      end else begin
        lane_q  <= lane_q + C_LANE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_r_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_r_drain : streams BRAM_R result rows to the PS over AXI4-Stream, gapless
// Rev 1.0
// ----------------------------------------------------------------------------
module bram_r_drain
  import simd_pkg::*;
#(
  parameter int unsigned PE_COUNT   = C_PE_COUNT,
  parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
  parameter int unsigned R_ADDR_W   = 11,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [R_ADDR_W-1:0]            base_addr,
  input  logic [R_ADDR_W:0]              num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [R_ADDR_W-1:0]            bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int unsigned C_ROW_W  = PE_COUNT * DATA_WIDTH;
  localparam int unsigned C_CNT_W  = R_ADDR_W + 1;
  localparam int unsigned C_BEAT_W = R_ADDR_W + 1 + idx_width(PE_COUNT);

  drain_state_t          state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [R_ADDR_W-1:0]   addr_q;
  logic [R_ADDR_W-1:0]   next_addr_q;
  logic [C_CNT_W-1:0]    fetch_cnt_q;
  logic [C_CNT_W-1:0]    load_cnt_q;
  logic [C_BEAT_W-1:0]   beats_left_q;
  logic [RD_LAT:0]       pipe_q;
  logic [C_ROW_W-1:0]    pf_q;
  logic                  pf_valid_q;
  logic                  pf_valid_d;

  logic                  w_active;
  logic                  w_land;
  logic                  w_ser_free;
  logic                  w_ser_load;
  logic                  w_load_pf;
  logic                  w_pf_capture;
  logic                  w_issue;
  logic                  w_hs;
  logic                  w_last_beat;
  logic [C_ROW_W-1:0]    w_ser_row;

  assign busy          = busy_q;
  assign done          = done_q;
  assign bram_r_r_addr = addr_q;

  assign w_active   = (state_q == DR_FETCH) || (state_q == DR_STREAM);
  // pipe_q[k] marks a read issued k cycles ago; stage RD_LAT is the data-valid cycle.
  assign w_land     = pipe_q[RD_LAT];
  assign w_ser_load = w_active && (pf_valid_q || w_land) && w_ser_free;
  assign w_load_pf  = w_ser_load && pf_valid_q;
  assign w_ser_row  = pf_valid_q ? pf_q : bram_r_r_data;

  // Landing data bypasses the buffer only when it goes straight into an empty serialiser.
  assign w_pf_capture = w_land && !(w_ser_load && !pf_valid_q);

  always_comb begin
    pf_valid_d = pf_valid_q;
    if (w_pf_capture) begin
      pf_valid_d = 1'b1;
    end else if (w_load_pf) begin
      pf_valid_d = 1'b0;
    end
  end

  // At most one read in flight, and only when its destination slot is guaranteed free.
  assign w_issue = w_active && (fetch_cnt_q != '0) && !(|pipe_q[RD_LAT-1:0]) && !pf_valid_d;

  assign w_hs        = m_axis_tvalid && m_axis_tready;
  assign w_last_beat = w_hs && (beats_left_q == C_BEAT_W'(1));

  row_serializer #(
    .PE_COUNT   (PE_COUNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_row_serializer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_ser_load),
    .row_i      (w_ser_row),
    .last_row_i (load_cnt_q == C_CNT_W'(1)),
    .tready_i   (m_axis_tready),
    .tdata_o    (m_axis_tdata),
    .tvalid_o   (m_axis_tvalid),
    .tlast_o    (m_axis_tlast),
    .free_o     (w_ser_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DR_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      fetch_cnt_q  <= '0;
      load_cnt_q   <= '0;
      beats_left_q <= '0;
      pipe_q       <= '0;
      pf_q         <= '0;
      pf_valid_q   <= 1'b0;
    end else begin
      pipe_q     <= {pipe_q[RD_LAT-1:0], w_issue};
      pf_valid_q <= pf_valid_d;
      if (w_pf_capture) begin
        pf_q <= bram_r_r_data;
      end

      case (state_q)
        DR_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (num_rows != '0) begin
              addr_q       <= base_addr;
              next_addr_q  <= base_addr + R_ADDR_W'(1);
              fetch_cnt_q  <= num_rows - C_CNT_W'(1);
              load_cnt_q   <= num_rows;
              beats_left_q <= C_BEAT_W'(num_rows) * C_BEAT_W'(PE_COUNT);
              pipe_q[0]    <= 1'b1;
              state_q      <= DR_FETCH;
            end else begin
              state_q      <= DR_FINISH;
            end
          end
        end

        DR_FETCH, DR_STREAM: begin
          if (w_issue) begin
            addr_q      <= next_addr_q;
            next_addr_q <= next_addr_q + R_ADDR_W'(1);
            fetch_cnt_q <= fetch_cnt_q - C_CNT_W'(1);
          end
          if (w_ser_load) begin
            load_cnt_q <= load_cnt_q - C_CNT_W'(1);
            if (state_q == DR_FETCH) begin
              state_q <= DR_STREAM;
            end
          end
          if (w_hs) begin
            beats_left_q <= beats_left_q - C_BEAT_W'(1);
          end
          if (w_last_beat) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DR_FINISH;
          end
        end

        DR_FINISH: begin
          // Entered with done already set after a stream; a zero-row drain raises it here.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= DR_IDLE;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= DR_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
